// File: rtl/mem_port_if.sv
// Bundle of the fetch, load/store and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mem_port_if #(parameter int AW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between fetch and load/store.
// Each access runs IDLE->ISSUE->(WAIT)->RESP. Data has priority, and an aging counter keeps fetch from starving.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_port_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic          own_fetch_q, own_fetch_d;
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          starved;
  logic          fetch_win;

  assign starved   = (starve_cnt_q == SW'(STARVE_MAX));
  assign fetch_win = bus.if_req && (!bus.d_req || starved);

  always_comb begin
    state_d      = state_q;
    own_fetch_d  = own_fetch_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d     = ISSUE;
          own_fetch_d = fetch_win;
          if (fetch_win) begin
            mem_addr_d   = bus.if_addr;
            we_d         = 1'b0;
            starve_cnt_d = '0;
          end else begin
            mem_addr_d  = bus.d_addr;
            we_d        = bus.d_we;
            mem_wdata_d = bus.d_wdata;
            // Registered so the write strobe is high exactly during ISSUE.
            mem_we_d    = bus.d_we;
            if (bus.if_req && !starved) starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        if (we_q) begin
          state_d = RESP;
          d_ack_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == CW'(RD_LAT - 1)) begin
          state_d = RESP;
          if (own_fetch_q) begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      own_fetch_q  <= 1'b1;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      own_fetch_q  <= own_fetch_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Requesters must hold their fields while a request is pending and not yet acked.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.if_req && $past(bus.if_req) && !$past(bus.if_ack)) |-> (bus.if_addr == $past(bus.if_addr)));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.d_req && $past(bus.d_req) && !$past(bus.d_ack)) |->
    (bus.d_addr == $past(bus.d_addr) && bus.d_we == $past(bus.d_we) && bus.d_wdata == $past(bus.d_wdata)));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: fetch, store/load, contention, starvation, reset mid-access and a RD_LAT=3 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_if #(.AW(32)) bus_a ();
  mem_port_if #(.AW(32)) bus_b ();

  mem_port_arbiter #(.AW(32), .RD_LAT(1), .STARVE_MAX(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.AW(32), .RD_LAT(3), .STARVE_MAX(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Memory models: synchronous write, read data delayed by RD_LAT cycles.
  logic [31:0] mem_a [0:255];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (mem_init) mem_a[8'h10] <= 32'hDEADBEEF;
    else if (bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    rd_a <= mem_a[bus_a.mem_addr[7:0]];
  end
  assign bus_a.mem_rdata = rd_a;

  logic [31:0] mem_b [0:255];
  logic [31:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    if (mem_init) mem_b[8'h20] <= 32'hCAFEF00D;
    else if (bus_b.mem_we) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
    pb0 <= mem_b[bus_b.mem_addr[7:0]];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bus_b.mem_rdata = pb2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nack;
    logic [31:0] exp_f;
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = 0; bus_b.d_wdata = 0;
    tick(); tick(); tick();
    rst = 0; mem_init = 0;

    // Reset state
    chk("rst_state", 32'(dut_a.state_q), 32'd0);
    chk("rst_if_ack", 32'(bus_a.if_ack), 32'd0);
    chk("rst_d_ack", 32'(bus_a.d_ack), 32'd0);
    chk("rst_if_rdata", bus_a.if_rdata, 32'd0);
    chk("rst_d_rdata", bus_a.d_rdata, 32'd0);
    chk("rst_mem_addr", bus_a.mem_addr, 32'd0);
    chk("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    chk("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
    chk("rst_starve", 32'(dut_a.starve_cnt_q), 32'd0);

    // 1: single fetch, RD_LAT=1
    bus_a.if_req = 1; bus_a.if_addr = 32'h10;
    tick(); chk("f_c1_addr", bus_a.mem_addr, 32'h10); chk("f_c1_ack", 32'(bus_a.if_ack), 32'd0);
    chk("f_c1_we", 32'(bus_a.mem_we), 32'd0);
    tick(); chk("f_c2_ack", 32'(bus_a.if_ack), 32'd0);
    tick(); chk("f_c3_ack", 32'(bus_a.if_ack), 32'd1); chk("f_c3_rdata", bus_a.if_rdata, 32'hDEADBEEF);
    chk("f_c3_dack", 32'(bus_a.d_ack), 32'd0);
    bus_a.if_req = 0;
    tick(); chk("f_c4_ack", 32'(bus_a.if_ack), 32'd0); chk("f_c4_hold", bus_a.if_rdata, 32'hDEADBEEF);
    chk("f_c4_addr_hold", bus_a.mem_addr, 32'h10);

    // 2: store then load
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 5; bus_a.d_wdata = 32'h1234;
    tick(); chk("st_c1_we", 32'(bus_a.mem_we), 32'd1); chk("st_c1_addr", bus_a.mem_addr, 32'd5);
    chk("st_c1_wdata", bus_a.mem_wdata, 32'h1234); chk("st_c1_ack", 32'(bus_a.d_ack), 32'd0);
    tick(); chk("st_c2_we", 32'(bus_a.mem_we), 32'd0); chk("st_c2_ack", 32'(bus_a.d_ack), 32'd1);
    chk("st_c2_rdata", bus_a.d_rdata, 32'd0);
    bus_a.d_req = 0;
    tick(); chk("st_c3_ack", 32'(bus_a.d_ack), 32'd0); chk("st_c3_we", 32'(bus_a.mem_we), 32'd0);
    bus_a.d_req = 1; bus_a.d_we = 0;
    tick(); chk("ld_c1_we", 32'(bus_a.mem_we), 32'd0);
    tick(); chk("ld_c2_ack", 32'(bus_a.d_ack), 32'd0);
    tick(); chk("ld_c3_ack", 32'(bus_a.d_ack), 32'd1); chk("ld_c3_rdata", bus_a.d_rdata, 32'h1234);
    chk("ld_if_rdata_kept", bus_a.if_rdata, 32'hDEADBEEF); chk("ld_if_ack", 32'(bus_a.if_ack), 32'd0);
    bus_a.d_req = 0;
    tick();

    // 3: contention, data wins first
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 5;
    bus_a.if_req = 1; bus_a.if_addr = 32'h10;
    tick(); chk("ct_c1_addr", bus_a.mem_addr, 32'd5);
    tick();
    tick(); chk("ct_c3_dack", 32'(bus_a.d_ack), 32'd1); chk("ct_c3_ifack", 32'(bus_a.if_ack), 32'd0);
    chk("ct_c3_starve", 32'(dut_a.starve_cnt_q), 32'd1);
    bus_a.d_req = 0;
    tick();
    tick(); chk("ct_c5_addr", bus_a.mem_addr, 32'h10);
    tick(); chk("ct_c6_ifack", 32'(bus_a.if_ack), 32'd0);
    tick(); chk("ct_c7_ifack", 32'(bus_a.if_ack), 32'd1); chk("ct_c7_dack", 32'(bus_a.d_ack), 32'd0);
    chk("ct_c7_starve", 32'(dut_a.starve_cnt_q), 32'd0);
    bus_a.if_req = 0;
    tick();

    // 4: starvation, both held high: D D D D F D D D D F
    bus_a.d_req = 1; bus_a.if_req = 1;
    nack = 0;
    for (int cyc = 0; cyc < 200 && nack < 10; cyc++) begin
      tick();
      if (bus_a.if_ack || bus_a.d_ack) begin
        exp_f = (nack == 4 || nack == 9) ? 32'd1 : 32'd0;
        chk($sformatf("starve_ack%0d_fetch", nack), 32'(bus_a.if_ack), exp_f);
        nack++;
      end
    end
    chk("starve_ack_count", 32'(nack), 32'd10);
    bus_a.d_req = 0; bus_a.if_req = 0;
    tick();

    // 5: reset during WAIT of a load, then a clean load
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 5;
    tick(); tick();
    rst = 1;
    tick(); chk("rl_ack", 32'(bus_a.d_ack), 32'd0); chk("rl_we", 32'(bus_a.mem_we), 32'd0);
    chk("rl_state", 32'(dut_a.state_q), 32'd0); chk("rl_rdata", bus_a.d_rdata, 32'd0);
    rst = 0; bus_a.d_req = 0;
    tick(); chk("rl_idle_ack", 32'(bus_a.d_ack), 32'd0);
    bus_a.d_req = 1;
    tick(); tick(); chk("rl2_c2_ack", 32'(bus_a.d_ack), 32'd0);
    tick(); chk("rl2_c3_ack", 32'(bus_a.d_ack), 32'd1); chk("rl2_rdata", bus_a.d_rdata, 32'h1234);
    bus_a.d_req = 0;
    tick();
    // reset during ISSUE of a store: no ack, strobe gone
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 6; bus_a.d_wdata = 32'h55;
    tick(); chk("rs_c1_we", 32'(bus_a.mem_we), 32'd1);
    rst = 1;
    tick(); chk("rs_c2_ack", 32'(bus_a.d_ack), 32'd0); chk("rs_c2_we", 32'(bus_a.mem_we), 32'd0);
    rst = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    tick(); chk("rs_c3_ack", 32'(bus_a.d_ack), 32'd0);

    // 6: RD_LAT=3 fetch
    bus_b.if_req = 1; bus_b.if_addr = 32'h20;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("l3_c%0d_addr", c), bus_b.mem_addr, 32'h20);
      chk($sformatf("l3_c%0d_ack", c), 32'(bus_b.if_ack), 32'd0);
    end
    tick(); chk("l3_c5_ack", 32'(bus_b.if_ack), 32'd1); chk("l3_c5_rdata", bus_b.if_rdata, 32'hCAFEF00D);
    bus_b.if_req = 0;
    tick(); chk("l3_c6_ack", 32'(bus_b.if_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
